// File: rtl/fu_result_buffer.sv
// Per-functional-unit result FIFO feeding the CDB arbiter: holds completed results
// and presents the oldest one as a request. Back-pressures the unit when full.
module fu_result_buffer #(
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  parameter int PRF_LEN = 6,
  parameter int ROB_LEN = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fu_valid,
  input  logic [XLEN-1:0]            fu_value,
  input  logic [PRF_LEN-1:0]         fu_prf_idx,
  input  logic [ROB_LEN-1:0]         fu_rob_idx,
  input  logic [XLEN-1:0]            fu_PC,
  output logic                       fu_ready,
  input  logic                       squash,
  input  logic                       cdb_grant,
  output logic                       cdb_req_valid,
  output logic [XLEN-1:0]            cdb_req_value,
  output logic [PRF_LEN-1:0]         cdb_req_prf_idx,
  output logic [ROB_LEN-1:0]         cdb_req_rob_idx,
  output logic [XLEN-1:0]            cdb_req_PC,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0]    value;
    logic [PRF_LEN-1:0] prf_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic [XLEN-1:0]    pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  entry_t          head_e;

  always_comb begin
    fu_ready = (count_q != CW'(DEPTH));
    push     = fu_valid & fu_ready & ~squash;
    pop      = cdb_grant & (count_q != '0) & ~squash;
    mem_d    = mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = '{value: fu_value, prf_idx: fu_prf_idx,
                          rob_idx: fu_rob_idx, pc: fu_PC};
        tail_d = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head_e = (count_q != '0) ? mem_q[head_q] : '0;
    cdb_req_valid   = (count_q != '0);
    cdb_req_value   = head_e.value;
    cdb_req_prf_idx = head_e.prf_idx;
    cdb_req_rob_idx = head_e.rob_idx;
    cdb_req_PC      = head_e.pc;
    count           = count_q;
  end
endmodule

// File: tb/tb_fu_result_buffer.sv
// Scoreboard bench for fu_result_buffer: a queue models buffer contents; outputs are
// compared mid-cycle against the queue head, count and readiness.
module tb_fu_result_buffer;
  logic        clock = 1'b0;
  logic        reset, fu_valid, squash, cdb_grant;
  logic [31:0] fu_value, fu_PC;
  logic [5:0]  fu_prf_idx;
  logic [4:0]  fu_rob_idx;
  logic        fu_ready, cdb_req_valid;
  logic [31:0] cdb_req_value, cdb_req_PC;
  logic [5:0]  cdb_req_prf_idx;
  logic [4:0]  cdb_req_rob_idx;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] v;
    logic [5:0]  p;
    logic [4:0]  r;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  fu_result_buffer #(.DEPTH(4), .XLEN(32), .PRF_LEN(6), .ROB_LEN(5)) dut (
    .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_value(fu_value),
    .fu_prf_idx(fu_prf_idx), .fu_rob_idx(fu_rob_idx), .fu_PC(fu_PC),
    .fu_ready(fu_ready), .squash(squash), .cdb_grant(cdb_grant),
    .cdb_req_valid(cdb_req_valid), .cdb_req_value(cdb_req_value),
    .cdb_req_prf_idx(cdb_req_prf_idx), .cdb_req_rob_idx(cdb_req_rob_idx),
    .cdb_req_PC(cdb_req_PC), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; outputs are checked mid-cycle, then the model takes the edge.
  task automatic step(input logic fv, input logic [31:0] v, input logic [5:0] p,
                      input logic [4:0] r, input logic [31:0] pc,
                      input logic g, input logic sq, input logic rst);
    ent_t exp_h;
    ent_t obs_h;
    int   sz;
    fu_valid = fv; fu_value = v; fu_prf_idx = p; fu_rob_idx = r; fu_PC = pc;
    cdb_grant = g; squash = sq; reset = rst;
    #4;
    sz    = q.size();
    exp_h = (sz != 0) ? q[0] : '0;
    obs_h = '{v: cdb_req_value, p: cdb_req_prf_idx, r: cdb_req_rob_idx, pc: cdb_req_PC};
    chk("count", 128'(count), 128'(sz));
    chk("fu_ready", 128'(fu_ready), 128'(sz != 4));
    chk("req_valid", 128'(cdb_req_valid), 128'(sz != 0));
    chk("req_head", 128'(obs_h), 128'(exp_h));
    if (rst || sq) begin
      q.delete();
    end else begin
      if (g && sz != 0) void'(q.pop_front());
      if (fv && sz != 4) q.push_back('{v: v, p: p, r: r, pc: pc});
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input logic g);
    step(1'b0, 32'h0, 6'h0, 5'h0, 32'h0, g, 1'b0, 1'b0);
  endtask

  task automatic push_v(input logic [31:0] v, input logic g);
    step(1'b1, v, v[5:0], v[4:0], v + 32'h1000, g, 1'b0, 1'b0);
  endtask

  initial begin
    fu_valid = 0; fu_value = 0; fu_prf_idx = 0; fu_rob_idx = 0; fu_PC = 0;
    cdb_grant = 0; squash = 0; reset = 1;
    @(posedge clock); #1;
    step(1'b0, 32'h0, 6'h0, 5'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Idle after reset with grant toggling
    for (int i = 0; i < 5; i++) idle(i[0]);

    // Single pass
    step(1'b1, 32'h1234, 6'd5, 5'd3, 32'h100, 1'b0, 1'b0, 1'b0);
    chk("sp_valid", 128'(cdb_req_valid), 128'(1'b1));
    chk("sp_value", 128'(cdb_req_value), 128'(32'h1234));
    chk("sp_prf", 128'(cdb_req_prf_idx), 128'(6'd5));
    chk("sp_rob", 128'(cdb_req_rob_idx), 128'(5'd3));
    chk("sp_pc", 128'(cdb_req_PC), 128'(32'h100));
    idle(1'b1);
    chk("sp_empty", 128'(cdb_req_valid), 128'(1'b0));

    // Fill to full, ignored extra push, drain in order
    for (int i = 0; i < 4; i++) push_v(32'hA0 + 32'(i), 1'b0);
    chk("full_cnt", 128'(count), 128'(3'd4));
    chk("full_rdy", 128'(fu_ready), 128'(1'b0));
    push_v(32'hBAD, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_val", 128'(cdb_req_value), 128'(32'hA0 + 32'(i)));
      idle(1'b1);
    end
    chk("drain_empty", 128'(count), 128'(3'd0));

    // Full with grant and push: grant pops, push refused
    for (int i = 0; i < 4; i++) push_v(32'hB0 + 32'(i), 1'b0);
    push_v(32'hBBB, 1'b1);
    chk("full_pop_rdy", 128'(fu_ready), 128'(1'b1));
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Streaming at count=2 across several wraps
    push_v(32'hC0, 1'b0);
    push_v(32'hC1, 1'b0);
    for (int i = 0; i < 10; i++) push_v(32'hC2 + 32'(i), 1'b1);
    chk("stream_cnt", 128'(count), 128'(3'd2));
    chk("stream_head", 128'(cdb_req_value), 128'(32'hCA));
    idle(1'b1);
    idle(1'b1);

    // Squash at count=3 with push and grant
    for (int i = 0; i < 3; i++) push_v(32'hD0 + 32'(i), 1'b0);
    step(1'b1, 32'hDEAD, 6'h1, 5'h1, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("sq_cnt", 128'(count), 128'(3'd0));
    chk("sq_valid", 128'(cdb_req_valid), 128'(1'b0));
    chk("sq_rdy", 128'(fu_ready), 128'(1'b1));
    idle(1'b1);

    // Reset at count=4 while granted
    for (int i = 0; i < 4; i++) push_v(32'hE0 + 32'(i), 1'b0);
    step(1'b1, 32'hFFFF, 6'h3, 5'h3, 32'h3, 1'b1, 1'b0, 1'b1);
    chk("rst_cnt", 128'(count), 128'(3'd0));
    chk("rst_val", 128'(cdb_req_value), 128'(32'h0));
    push_v(32'h55, 1'b0);
    chk("rst_push_val", 128'(cdb_req_value), 128'(32'h55));
    chk("rst_push_pc", 128'(cdb_req_PC), 128'(32'h1055));
    idle(1'b1);
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fu_result_buffer.md
# fu_result_buffer

- Per-functional-unit result FIFO between an execution unit (ALU, MUL, MEM or BRANCH) and the single-winner CDB arbiter.
- Captures completed results and presents the oldest one to the arbiter as a request.
- Pops that entry when the arbiter grants this unit.
- Back-pressures the execution unit when full, so results that lose arbitration are never dropped.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- XLEN, 32, result and PC width
- PRF_LEN, 6, physical register index width
- ROB_LEN, 5, ROB index width

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clears all state
- fu_valid  in  1  execution unit presents a result this cycle
- fu_value  in  XLEN  result value
- fu_prf_idx  in  PRF_LEN  destination physical register
- fu_rob_idx  in  ROB_LEN  ROB entry of the instruction
- fu_PC  in  XLEN  instruction PC
- fu_ready  out  1  buffer can accept a result this cycle
- squash  in  1  mispredict flush; discards all entries
- cdb_grant  in  1  arbiter selected this unit this cycle
- cdb_req_valid  out  1  head entry valid, requesting the CDB
- cdb_req_value  out  XLEN  head value
- cdb_req_prf_idx  out  PRF_LEN  head destination register
- cdb_req_rob_idx  out  ROB_LEN  head ROB index
- cdb_req_PC  out  XLEN  head PC
- count  out  log2(DEPTH)+1  number of valid entries

## Operation
- Storage: circular array of DEPTH entries {value, prf_idx, rob_idx, PC}.
  - Head and tail pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - count register ranges 0..DEPTH.
- fu_ready = (count != DEPTH). Combinational from count only; it does not depend on cdb_grant in the same cycle.
- push = fu_valid & fu_ready & ~squash.
  - Writes the entry at tail; tail increments.
  - fu_valid while fu_ready=0 is a protocol violation; the buffer ignores it.
- pop = cdb_grant & (count != 0) & ~squash.
  - Head increments.
  - cdb_grant while empty is ignored.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- squash: head, tail and count go to 0 next cycle. Any push or pop in the same cycle is discarded.
- reset has priority over squash and has the same effect.
- Request outputs:
  - cdb_req_valid = (count != 0).
  - cdb_req_* fields show the head entry when count != 0, and all-zero when empty.
  - All request outputs are combinational from registered state only (no fu_* to cdb_req_* path), so the arbiter sees a stable request all cycle.
- Ordering: results leave in arrival order. No reordering by ROB age.

## Timing
- Reset values: cdb_req_valid=0, all cdb_req_* fields=0, count=0, fu_ready=1.
- Latency: a result pushed in cycle N appears at cdb_req_* in cycle N+1 at the earliest. There is no bypass from fu_* to the outputs.
- Grant in cycle N with count=k (k > 0): in cycle N+1 the next entry is at the head and count=k-1, or count=k if a push occurred in the same cycle.
- Full (count=DEPTH): fu_ready=0. A grant in that cycle pops, and fu_ready returns to 1 in the following cycle.
- Empty with push in cycle N: cdb_req_valid rises in cycle N+1.
- Wrap-around: after DEPTH pushes the tail is back at entry 0. Data integrity must hold across any number of wraps.
- squash in cycle N: cdb_req_valid=0 and count=0 in cycle N+1; fu_ready=1 in N+1.
- Reset asserted mid-operation: the same as squash, plus it overrides everything. No entry survives.

## Test plan
- Reset, then idle: cdb_req_valid=0, all fields 0, count=0, fu_ready=1 for 5 cycles with cdb_grant toggling.
- Single pass: push {value=0x1234, prf=5, rob=3, PC=0x100} in cycle 1 → cdb_req_valid=1 with those fields in cycle 2; grant in cycle 2 → count=0, cdb_req_valid=0 in cycle 3.
- Fill to full: 4 pushes with no grant → count=4, fu_ready=0. Push attempt in cycle 5 is ignored. Then grant for 4 cycles → values pop in order 0xA0, 0xA1, 0xA2, 0xA3, then empty.
- Simultaneous push and pop at count=2, 10 cycles in a row with incrementing values → count stays 2. Output order matches input order across at least two pointer wraps.
- squash at count=3, with fu_valid=1 and cdb_grant=1 in the same cycle → next cycle count=0, cdb_req_valid=0, fu_ready=1. The squashed-cycle push never appears.
- Reset asserted at count=4 while granted → next cycle all outputs at their reset values. A push in the following cycle reads back correctly.
